// File: rtl/score_pkg.sv
// Shared types and constants for the melody sequencer: FSM states,
// score entry layout, note codes and the default divisor table.
package score_pkg;

   localparam int ENTRY_W  = 5;
   localparam int NOTE_W   = 3;
   localparam int DUR_W    = 2;
   localparam int ADDR_W   = 6;
   localparam int PERIOD_W = 18;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PLAY,
      GAP,
      DONE
   } state_t;

   typedef logic [NOTE_W-1:0] note_t;

   localparam note_t NOTE_REST = 3'd0;
   localparam note_t NOTE_DO   = 3'd1;
   localparam note_t NOTE_RE   = 3'd2;
   localparam note_t NOTE_MI   = 3'd3;
   localparam note_t NOTE_FA   = 3'd4;
   localparam note_t NOTE_SO   = 3'd5;
   localparam note_t NOTE_LA   = 3'd6;
   localparam note_t NOTE_XI   = 3'd7;

   // Half-period divisors at 50 MHz for the seven scale notes.
   localparam logic [PERIOD_W-1:0] DEF_DO = 18'd190840;
   localparam logic [PERIOD_W-1:0] DEF_RE = 18'd170068;
   localparam logic [PERIOD_W-1:0] DEF_MI = 18'd151515;
   localparam logic [PERIOD_W-1:0] DEF_FA = 18'd143266;
   localparam logic [PERIOD_W-1:0] DEF_SO = 18'd127551;
   localparam logic [PERIOD_W-1:0] DEF_LA = 18'd113636;
   localparam logic [PERIOD_W-1:0] DEF_XI = 18'd101214;

   // One score entry: note code in the top bits, duration code d (d+1 beats) below.
   typedef struct packed {
      note_t             note;
      logic [DUR_W-1:0]  dur;
   } entry_t;

   function automatic entry_t make_entry(input note_t note, input logic [DUR_W-1:0] dur);
      entry_t e;
      e.note = note;
      e.dur  = dur;
      return e;
   endfunction

endpackage

// File: rtl/score_rom.sv
// Score ROM: constant case table indexed by address, registered read port.
// SONG selects the table: 0 = default melody, 1 = short three-entry test score.
module score_rom
   import score_pkg::*;
#(
   parameter int SONG = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   output entry_t            data
);

   entry_t rom_d;

   // Table lookup for the selected song.
   always_comb begin
      // NOTE: assign a default before the case so unlisted addresses never infer a latch.
      rom_d = make_entry(NOTE_REST, 2'd0);
      if (SONG == 1) begin
         case (addr)
            6'd0:    rom_d = make_entry(NOTE_DO,   2'd0);
            6'd1:    rom_d = make_entry(NOTE_REST, 2'd1);
            6'd2:    rom_d = make_entry(NOTE_XI,   2'd3);
            default: rom_d = make_entry(NOTE_REST, 2'd0);
         endcase
      end else begin
         case (addr)
            6'd0:    rom_d = make_entry(NOTE_DO,   2'd0);
            6'd1:    rom_d = make_entry(NOTE_DO,   2'd0);
            6'd2:    rom_d = make_entry(NOTE_SO,   2'd0);
            6'd3:    rom_d = make_entry(NOTE_SO,   2'd0);
            6'd4:    rom_d = make_entry(NOTE_LA,   2'd0);
            6'd5:    rom_d = make_entry(NOTE_LA,   2'd0);
            6'd6:    rom_d = make_entry(NOTE_SO,   2'd1);
            6'd7:    rom_d = make_entry(NOTE_FA,   2'd0);
            6'd8:    rom_d = make_entry(NOTE_FA,   2'd0);
            6'd9:    rom_d = make_entry(NOTE_MI,   2'd0);
            6'd10:   rom_d = make_entry(NOTE_MI,   2'd0);
            6'd11:   rom_d = make_entry(NOTE_RE,   2'd0);
            6'd12:   rom_d = make_entry(NOTE_RE,   2'd0);
            6'd13:   rom_d = make_entry(NOTE_DO,   2'd1);
            6'd14:   rom_d = make_entry(NOTE_SO,   2'd0);
            6'd15:   rom_d = make_entry(NOTE_SO,   2'd0);
            6'd16:   rom_d = make_entry(NOTE_FA,   2'd0);
            6'd17:   rom_d = make_entry(NOTE_FA,   2'd0);
            6'd18:   rom_d = make_entry(NOTE_MI,   2'd0);
            6'd19:   rom_d = make_entry(NOTE_MI,   2'd0);
            6'd20:   rom_d = make_entry(NOTE_RE,   2'd1);
            6'd21:   rom_d = make_entry(NOTE_SO,   2'd0);
            6'd22:   rom_d = make_entry(NOTE_SO,   2'd0);
            6'd23:   rom_d = make_entry(NOTE_FA,   2'd0);
            6'd24:   rom_d = make_entry(NOTE_FA,   2'd0);
            6'd25:   rom_d = make_entry(NOTE_MI,   2'd0);
            6'd26:   rom_d = make_entry(NOTE_MI,   2'd0);
            6'd27:   rom_d = make_entry(NOTE_RE,   2'd1);
            6'd28:   rom_d = make_entry(NOTE_DO,   2'd0);
            6'd29:   rom_d = make_entry(NOTE_DO,   2'd0);
            6'd30:   rom_d = make_entry(NOTE_SO,   2'd1);
            6'd31:   rom_d = make_entry(NOTE_REST, 2'd3);
            default: rom_d = make_entry(NOTE_REST, 2'd0);
         endcase
      end
   end

   // Registered read port.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: only the read register is reset; the table itself is constant logic with no state.
      if (!rst_n) data <= make_entry(NOTE_REST, 2'd0);
      else        data <= rom_d;
   end

endmodule

// File: rtl/score_sequencer.sv
// Melody sequencer: walks the score ROM on a start pulse, presenting each note's
// half-period divisor for d+1 beats followed by a short silent gap.
module score_sequencer
   import score_pkg::*;
#(
   parameter logic [24:0]          TIME_BEAT = 25'd24_999_999,
   parameter logic [15:0]          GAP_CYC   = 16'd49_999,
   parameter int unsigned          SCORE_LEN = 32,
   parameter logic [PERIOD_W-1:0]  DO        = DEF_DO,
   parameter logic [PERIOD_W-1:0]  RE        = DEF_RE,
   parameter logic [PERIOD_W-1:0]  MI        = DEF_MI,
   parameter logic [PERIOD_W-1:0]  FA        = DEF_FA,
   parameter logic [PERIOD_W-1:0]  SO        = DEF_SO,
   parameter logic [PERIOD_W-1:0]  LA        = DEF_LA,
   parameter logic [PERIOD_W-1:0]  XI        = DEF_XI,
   parameter int                   SONG      = 0
) (
   input  logic                i_sysclk,
   input  logic                i_sysrst_n,
   input  logic                i_play,
   input  logic                i_stop,
   input  logic                i_loop,
   output logic [PERIOD_W-1:0] o_note_period,
   output logic                o_note_valid,
   output logic                o_busy,
   output logic                o_done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCORE_LEN - 1);

   state_t                state, state_nxt;
   logic [24:0]           beat_cnt, beat_cnt_nxt;
   logic [DUR_W-1:0]      beat_idx, beat_idx_nxt;
   logic [15:0]           gap_cnt, gap_cnt_nxt;
   logic [ADDR_W-1:0]     addr, addr_nxt;
   logic [PERIOD_W-1:0]   period_nxt;
   logic                  valid_nxt;
   logic                  busy_nxt;
   logic                  done_nxt;
   entry_t                rom_q;

   function automatic logic [PERIOD_W-1:0] note_period(input note_t code);
      case (code)
         NOTE_DO: return DO;
         NOTE_RE: return RE;
         NOTE_MI: return MI;
         NOTE_FA: return FA;
         NOTE_SO: return SO;
         NOTE_LA: return LA;
         NOTE_XI: return XI;
         default: return '0;
      endcase
   endfunction

   // The ROM samples the next address, so the new entry is already registered
   // by the LOAD cycle and stays put while the address is held through PLAY.
   score_rom #(
      .SONG (SONG)
   ) u_rom (
      .clk   (i_sysclk),
      .rst_n (i_sysrst_n),
      .addr  (addr_nxt),
      .data  (rom_q)
   );

   // Next-state, counter and output decode; stop overrides everything outside IDLE.
   always_comb begin
      state_nxt    = state;
      beat_cnt_nxt = beat_cnt;
      beat_idx_nxt = beat_idx;
      gap_cnt_nxt  = gap_cnt;
      addr_nxt     = addr;
      period_nxt   = o_note_period;
      valid_nxt    = 1'b0;
      done_nxt     = 1'b0;

      if (state != IDLE && i_stop) begin
         state_nxt    = IDLE;
         beat_cnt_nxt = '0;
         beat_idx_nxt = '0;
         gap_cnt_nxt  = '0;
         addr_nxt     = '0;
         period_nxt   = '0;
         valid_nxt    = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               addr_nxt     = '0;
               beat_cnt_nxt = '0;
               beat_idx_nxt = '0;
               gap_cnt_nxt  = '0;
               if (i_play && !i_stop) state_nxt = LOAD;
            end

            LOAD: begin
               state_nxt    = PLAY;
               period_nxt   = note_period(rom_q.note);
               valid_nxt    = 1'b1;
               beat_cnt_nxt = '0;
               beat_idx_nxt = '0;
            end

            PLAY: begin
               if (beat_cnt == TIME_BEAT) begin
                  beat_cnt_nxt = '0;
                  if (beat_idx == rom_q.dur) begin
                     beat_idx_nxt = '0;
                     gap_cnt_nxt  = '0;
                     period_nxt   = '0;
                     valid_nxt    = 1'b1;
                     state_nxt    = GAP;
                  end else begin
                     beat_idx_nxt = beat_idx + 2'd1;
                  end
               end else begin
                  beat_cnt_nxt = beat_cnt + 25'd1;
               end
            end

            GAP: begin
               if (gap_cnt == GAP_CYC) begin
                  gap_cnt_nxt = '0;
                  if (addr != LAST_ADDR) begin
                     addr_nxt  = addr + 6'd1;
                     state_nxt = LOAD;
                  end else if (i_loop) begin
                     addr_nxt  = '0;
                     state_nxt = LOAD;
                  end else begin
                     done_nxt  = 1'b1;
                     state_nxt = DONE;
                  end
               end else begin
                  gap_cnt_nxt = gap_cnt + 16'd1;
               end
            end

            DONE: state_nxt = IDLE;

            default: state_nxt = IDLE;
         endcase
      end

      busy_nxt = (state_nxt != IDLE);
   end

   // State, counters and registered outputs.
   always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
      if (!i_sysrst_n) begin
         state         <= IDLE;
         beat_cnt      <= '0;
         beat_idx      <= '0;
         gap_cnt       <= '0;
         addr          <= '0;
         o_note_period <= '0;
         o_note_valid  <= 1'b0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register sees the pre-edge values of the others.
         state         <= state_nxt;
         beat_cnt      <= beat_cnt_nxt;
         beat_idx      <= beat_idx_nxt;
         gap_cnt       <= gap_cnt_nxt;
         addr          <= addr_nxt;
         o_note_period <= period_nxt;
         o_note_valid  <= valid_nxt;
         o_busy        <= busy_nxt;
         o_done        <= done_nxt;
      end
   end

endmodule
